// File: rtl/call_stack_if.sv
// Handshake bundle between prefetch (master) and the return-address stack (slave).
// Carries push/pop strobes, the pushed address, clr_err and the stack status.
interface call_stack_if #(
  parameter int NBITS = 9,
  parameter int DEPTH = 10
);
  localparam int NCNT = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic             clr_err;
  logic [NBITS-1:0] in;
  logic [NBITS-1:0] out;
  logic [NCNT-1:0]  level;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  modport master (
    output push, pop, clr_err, in,
    input  out, level, empty, full, ovf, unf
  );

  modport slave (
    input  push, pop, clr_err, in,
    output out, level, empty, full, ovf, unf
  );
endinterface

// File: rtl/call_stack.sv
// Return-address stack: CAL/ITR push the return PC, RET pops it.
// Cached top register drives out, so the popped PC is valid in the pop cycle.
// Ports: clk, rst (sync, active-high); bus (slave): push, pop, in, clr_err
//   -> out (top), level (0..DEPTH), empty, full, ovf/unf (sticky errors).
// Optional macro CALL_STACK_CHK_EN: reject push on full, flag ovf/unf.
// Without it, push on full drops the oldest entry and ovf=unf=0.
module call_stack #(
  parameter int NBITS = 9,
  parameter int DEPTH = 10
) (
  input  logic         clk,
  input  logic         rst,
  call_stack_if.slave  bus
);
  localparam int NCNT = $clog2(DEPTH + 1);
  localparam int MW   = DEPTH - 1;
  localparam int PW   = (MW > 1) ? $clog2(MW) : 1;

  logic [NBITS-1:0] top;
  logic [NBITS-1:0] mem [0:MW-1];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    wp_inc;
  logic [PW-1:0]    wp_dec;
  logic [NCNT-1:0]  level;
  logic             ovf_q;
  logic             unf_q;

  logic is_empty;
  logic is_full;
  logic rep;
  logic psh;
  logic pp;
  logic push_ok;
  logic spill;

  assign is_empty = (level == '0);
  assign is_full  = (level == NCNT'(DEPTH));

  // Push+pop on a non-empty stack replaces the top; on empty it is a push.
  assign rep = bus.push & bus.pop & ~is_empty;
  assign psh = bus.push & ~rep;
  assign pp  = bus.pop & ~bus.push;

`ifdef CALL_STACK_CHK_EN
  assign push_ok = psh & ~is_full;
`else
  assign push_ok = psh;
`endif

  // Old top moves into the array whenever a push lands on a non-empty stack.
  assign spill = push_ok & ~is_empty;

  assign wp_inc = (wp == PW'(MW - 1)) ? '0 : wp + 1'b1;
  assign wp_dec = (wp == '0) ? PW'(MW - 1) : wp - 1'b1;

  always_ff @(posedge clk) begin
    if (!rst && spill) begin
      mem[wp] <= top;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top   <= '0;
      level <= '0;
      wp    <= '0;
    end else begin
      unique case (1'b1)
        rep: begin
          top <= bus.in;
        end
        push_ok: begin
          top <= bus.in;
          if (is_empty) begin
            level <= NCNT'(1);
          end else begin
            wp <= wp_inc;
            // On full, wp wraps onto the oldest word.
            if (!is_full) level <= level + 1'b1;
          end
        end
        (pp && level > NCNT'(1)): begin
          top   <= mem[wp_dec];
          wp    <= wp_dec;
          level <= level - 1'b1;
        end
        (pp && level == NCNT'(1)): begin
          // Last entry leaves; top keeps its stale value.
          level <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef CALL_STACK_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~bus.clr_err) | (psh & is_full);
      unf_q <= (unf_q & ~bus.clr_err) | (pp & is_empty);
    end
  end
`else
  logic unused_clr;
  assign unused_clr = bus.clr_err;
  assign ovf_q = 1'b0;
  assign unf_q = 1'b0;
`endif

  assign bus.out   = top;
  assign bus.level = level;
  assign bus.empty = is_empty;
  assign bus.full  = is_full;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
endmodule
